// File: rtl/aes_spi_slave_if.sv
// aes_spi_slave_if: serial load/readback front end terminating the AES link
// Ports: clk, reset (sync, active-high); cs (active low), mosi, mode (0 load / 1 readback)
// from the link master; miso (registered, LSB first); aes_start/aes_msg/aes_key to the core,
// aes_done/aes_result from it; busy while a frame is in flight; frame_err pulses on aborts.
module aes_spi_slave_if #(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              mosi,
    input  logic              mode,
    output logic              miso,
    output logic              aes_start,
    output logic [127:0]      aes_msg,
    output logic [32*NK-1:0]  aes_key,
    input  logic              aes_done,
    input  logic [127:0]      aes_result,
    output logic              busy,
    output logic              frame_err
);
    localparam int KEY_W = 32 * NK;
    localparam logic [7:0] KEY_LAST = 8'(KEY_W - 1);

    typedef enum logic [2:0] {IDLE, RX_MSG, RX_KEY, START, WAIT_CORE, READY, TX, DONE} state_t;

    state_t           state, state_d;
    logic [7:0]       cnt;
    logic             pad, err, shift, tx_bit;
    logic [127:0]     msg_sr, result;
    logic [KEY_W-1:0] key_sr;

    assign busy   = state != IDLE && state != DONE;
    assign shift  = (state == RX_MSG || state == RX_KEY) && !cs && !mode && !pad;
    // READY drives bit 0; each TX edge drives the bit after the ones already sent
    assign tx_bit = state == TX ? result[cnt[6:0] + 7'd1] : result[0];

    always_comb begin
        state_d = state;
        err     = 1'b0;
        case (state)
            IDLE:      if (!cs && !mode) state_d = RX_MSG;
            RX_MSG, RX_KEY: begin
                if (cs || mode) begin
                    state_d = IDLE;
                    err     = 1'b1;
                end else if (pad) state_d = state == RX_MSG ? RX_KEY : START;
            end
            START: begin
                state_d = cs ? IDLE : WAIT_CORE;
                err     = cs;
            end
            WAIT_CORE: if (aes_done) state_d = READY;
            READY:     if (!cs && mode) state_d = TX;
            TX: begin
                if (cs) begin
                    state_d = IDLE;
                    err     = 1'b1;
                end else if (cnt == 8'd126) state_d = DONE;
            end
            DONE: begin
                if (cs) state_d = IDLE;
                else if (!mode) state_d = RX_MSG;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            pad       <= 1'b0;
            msg_sr    <= '0;
            key_sr    <= '0;
            result    <= '0;
            aes_msg   <= '0;
            aes_key   <= '0;
            aes_start <= 1'b0;
            miso      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            frame_err <= err;
            aes_start <= state == START && state_d == WAIT_CORE;
            miso      <= (state_d == TX || (state == TX && state_d == DONE)) ? tx_bit : 1'b0;
            // pad flags that the data bits are in, so the next sample is the trailing pad;
            // this keeps the count within 8 bits even for a 256-bit key
            if (state_d != state) begin
                cnt <= 8'd0;
                pad <= 1'b0;
            end else if (shift) begin
                if (cnt == (state == RX_MSG ? 8'd127 : KEY_LAST)) pad <= 1'b1;
                else cnt <= cnt + 8'd1;
            end else if (state == TX) cnt <= cnt + 8'd1;
            if (shift && state == RX_MSG) msg_sr <= {mosi, msg_sr[127:1]};
            if (shift && state == RX_KEY) key_sr <= {mosi, key_sr[KEY_W-1:1]};
            if (state == START && state_d == WAIT_CORE) begin
                aes_msg <= msg_sr;
                aes_key <= key_sr;
            end
            if (state == WAIT_CORE && aes_done) result <= aes_result;
        end
    end
endmodule

// File: tb/tb_aes_spi_slave_if.sv
// tb_aes_spi_slave_if: directed/randomized bench for aes_spi_slave_if (NK=4 and NK=8 instances)
module tb_aes_spi_slave_if;
    logic clk = 1'b0, reset = 1'b1, cs = 1'b1, cs8 = 1'b1, mosi = 1'b0, mode = 1'b0, done = 1'b0;
    logic [127:0] result = '0;
    logic miso, start, busy, ferr, miso8, start8, busy8, ferr8;
    logic [127:0] amsg, akey, amsg8, rv;
    logic [255:0] akey8;
    logic [127:0] mv;
    logic [255:0] kv;
    logic [127:0] saved;
    int checks = 0, errors = 0, nst = 0, s0;
    logic any;

    always #5 clk = ~clk;
    always @(posedge clk) if (start) nst <= nst + 1;

    aes_spi_slave_if #(.NK(4)) dut (
        .clk(clk), .reset(reset), .cs(cs), .mosi(mosi), .mode(mode), .miso(miso),
        .aes_start(start), .aes_msg(amsg), .aes_key(akey), .aes_done(done),
        .aes_result(result), .busy(busy), .frame_err(ferr)
    );

    aes_spi_slave_if #(.NK(8)) dut8 (
        .clk(clk), .reset(reset), .cs(cs8), .mosi(mosi), .mode(mode), .miso(miso8),
        .aes_start(start8), .aes_msg(amsg8), .aes_key(akey8), .aes_done(done),
        .aes_result(result), .busy(busy8), .frame_err(ferr8)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] r128;
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Load frame: pad, msg LSB first, pad, key LSB first, pad; aes_start must appear on
    // edge 132+kw counting the first-sample edge as edge 1
    task automatic send_frame(input logic [127:0] m, input logic [255:0] k, input int kw, input bit big);
        int n;
        mode = 1'b0;
        if (big) cs8 = 1'b0;
        else cs = 1'b0;
        s0 = nst;
        for (int i = 0; i < 131 + kw; i++) begin
            mosi = (i >= 1 && i <= 128) ? m[i-1] : (i >= 130 && i < 130 + kw) ? k[i-130] : 1'($urandom);
            tick;
        end
        n = 131 + kw;
        while (!(big ? start8 : start) && n < 140 + kw) begin
            tick;
            n++;
        end
        check("start_latency", n, 132 + kw);
        check("aes_msg", big ? amsg8 : amsg, m);
        check("aes_key", big ? akey8 : {128'b0, akey}, k);
        tick;
        check("start_one_cycle", big ? start8 : start, 1'b0);
        if (!big) check("start_once", nst - s0, 1);
    endtask

    task automatic core(input logic [127:0] r, input int lat);
        repeat (lat) tick;
        result = r;
        done = 1'b1;
        tick;
        done = 1'b0;
        result = r128();
    endtask

    task automatic readback(input logic [127:0] r, input bit first_zero, input bit big);
        logic [127:0] got;
        mode = 1'b1;
        if (first_zero) check("rb_sample1", big ? miso8 : miso, 1'b0);
        check("rb_busy", big ? busy8 : busy, 1'b1);
        for (int k = 0; k < 128; k++) begin
            tick;
            got[k] = big ? miso8 : miso;
        end
        check("rb_data", got, r);
        tick;
        check("rb_miso_after", big ? miso8 : miso, 1'b0);
        check("rb_busy_after", big ? busy8 : busy, 1'b0);
        mode = 1'b0;
        cs = 1'b1;
        cs8 = 1'b1;
        tick;
    endtask

    initial begin
        tick;
        tick;
        check("rst_miso", miso, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_msg", amsg, 128'b0);
        check("rst_key", akey, 128'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        reset = 1'b0;
        tick;

        // FIPS-197 vector, then readback of the known ciphertext after 12 cycles
        send_frame(128'h3243f6a8885a308d313198a2e0370734,
                   {128'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c}, 128, 1'b0);
        core(128'h3925841d02dc09fbdc118597196a0b32, 12);
        readback(128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 1'b0);

        // abort at msg bit 64
        saved = amsg;
        s0 = nst;
        cs = 1'b0;
        for (int i = 0; i < 65; i++) begin
            mosi = 1'($urandom);
            tick;
        end
        cs = 1'b1;
        tick;
        check("abort_ferr", ferr, 1'b1);
        check("abort_idle", busy, 1'b0);
        tick;
        check("abort_ferr_pulse", ferr, 1'b0);
        repeat (5) tick;
        check("abort_no_start", nst - s0, 0);
        check("abort_msg_kept", amsg, saved);
        mv = r128();
        kv = {128'b0, r128()};
        rv = r128();
        send_frame(mv, kv, 128, 1'b0);
        core(rv, 7);
        readback(rv, 1'b1, 1'b0);

        // mode=1 during key reception
        cs = 1'b0;
        for (int i = 0; i < 140; i++) begin
            mosi = 1'($urandom);
            tick;
        end
        mode = 1'b1;
        tick;
        check("mode_abort_ferr", ferr, 1'b1);
        check("mode_abort_idle", busy, 1'b0);
        mode = 1'b0;
        cs = 1'b1;
        tick;

        // mode=1 raised 5 cycles before aes_done
        mv = r128();
        kv = {128'b0, r128()};
        rv = r128();
        send_frame(mv, kv, 128, 1'b0);
        repeat (4) tick;
        mode = 1'b1;
        any = 1'b0;
        repeat (5) begin
            tick;
            any = any | miso;
        end
        check("early_mode_miso", any, 1'b0);
        result = rv;
        done = 1'b1;
        tick;
        done = 1'b0;
        result = r128();
        check("early_mode_ready_miso", miso, 1'b0);
        readback(rv, 1'b0, 1'b0);

        // reset during TX bit 40, then a clean frame
        mv = r128();
        kv = {128'b0, r128()};
        rv = r128();
        send_frame(mv, kv, 128, 1'b0);
        core(rv, 12);
        mode = 1'b1;
        repeat (40) tick;
        reset = 1'b1;
        tick;
        check("txrst_miso", miso, 1'b0);
        check("txrst_busy", busy, 1'b0);
        check("txrst_msg", amsg, 128'b0);
        reset = 1'b0;
        mode = 1'b0;
        cs = 1'b1;
        tick;
        mv = r128();
        kv = {128'b0, r128()};
        rv = r128();
        send_frame(mv, kv, 128, 1'b0);
        core(rv, 3);
        readback(rv, 1'b1, 1'b0);

        // NK=8: 256-bit key
        mv = r128();
        kv = {r128(), r128()};
        rv = r128();
        send_frame(mv, kv, 256, 1'b1);
        core(rv, 5);
        readback(rv, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
